prog_loader: RTL and testbench

//  Writer side of the program memory: takes a byte stream (UART RX / host link), frames it into
//  24-bit instruction words {opcode[7:0], operand[15:0]} and writes them into program RAM via a

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_word_assembler.sv | 52 +++++
 rtl/prog_loader.sv | 174 +++++++++++++++++
 tb/tb_prog_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg
//   Shared definitions for the program loader: frame start marker default,
//   3-bit FSM state encodings and the bytes-per-word helper.
//   Optional feature macro used by the loader: PROG_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
package prog_loader_pkg;

    // Default frame start marker.
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Loader FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_FIN   = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // Number of bytes that make up one program word.
    function automatic int bytes_per_word(input int word_width);
        return word_width / 8;
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
//   Byte shift register plus byte index counter. Bytes arrive MSB first; the
//   word output already includes the byte presented on byte_in, so the
//   caller can capture a complete word in the same cycle it accepts the last
//   byte (word_full high).
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : return byte index to 0 and clear the shift register
//   shift_en   : byte_in is accepted this cycle
//   byte_in    : incoming byte
//   word       : shift register contents with byte_in shifted in
//   word_full  : byte_in is the last byte of the current word
// ---------------------------------------------------------------------------
module word_assembler
    import prog_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            byte_in,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_full
);

    localparam int BPW   = bytes_per_word(WORD_WIDTH);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [WORD_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]      idx;

    // Upper byte falls off the top; the cast keeps this legal for BPW == 1.
    assign word      = WORD_WIDTH'({shreg, byte_in});
    assign word_full = shift_en && (idx == IDX_W'(BPW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            idx   <= '0;
        end else if (clear) begin
            shreg <= '0;
            idx   <= '0;
        end else if (shift_en) begin
            shreg <= word;
            idx   <= word_full ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Writer side of the program memory. Frames an incoming byte stream into
//   WORD_WIDTH-bit instruction words and writes them through a single write
//   port, holding the CPU in reset while a program is being loaded.
//   Frame: SYNC_BYTE, LEN (0 = 256 words), LEN*BPW data bytes MSB first,
//   and, when PROG_LOADER_CHECKSUM_EN is defined, a CHK byte equal to the XOR
//   of LEN and all data bytes.
// Handshake: a byte is taken on a rising edge where rx_valid && rx_ready;
//   rx_ready is registered, high in IDLE/LEN/DATA/CHK and low in
//   WRITE/FIN/ERR and while rst is high. rx_data must be stable while
//   rx_valid is high and not yet accepted.
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   rx_data    : incoming byte          rx_valid : rx_data valid
//   rx_ready   : loader accepts a byte
//   mem_we     : write strobe, one cycle per word
//   mem_addr   : write address          mem_data : write word
//   cpu_hold   : keep CPU in reset
//   load_done  : one-cycle pulse on a successful frame
//   load_err   : sticky frame error, cleared by the next accepted SYNC_BYTE
// Configuration macro: PROG_LOADER_CHECKSUM_EN
// ---------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         WORD_WIDTH = 24,
    parameter int         ADDR_BITS  = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    state_t                state;
    logic [8:0]            remaining;   // 9 bits so LEN=0 can count 256 words
    logic                  accept;
    logic                  asm_clear;
    logic                  asm_shift;
    logic [WORD_WIDTH-1:0] asm_word;
    logic                  asm_full;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]            chk;
`endif

    assign accept    = rx_valid && rx_ready;
    // The assembler only ever stops mid-word on reset, so parking it in IDLE
    // is enough to start every frame at byte index 0.
    assign asm_clear = (state == ST_IDLE);
    assign asm_shift = accept && (state == ST_DATA);

    word_assembler #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .byte_in   (rx_data),
        .word      (asm_word),
        .word_full (asm_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            remaining <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk       <= '0;
`endif
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rx_ready <= 1'b1;
                    // Anything other than the marker is line noise.
                    if (accept && (rx_data == SYNC_BYTE)) begin
                        state    <= ST_LEN;
                        cpu_hold <= 1'b1;
                        load_err <= 1'b0;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        remaining <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        mem_addr  <= '0;
                        state     <= ST_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk       <= rx_data;
`endif
                    end
                end
                ST_DATA: begin
                    if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk <= chk ^ rx_data;
`endif
                        // Capture the word in the same edge that takes its
                        // last byte so the strobe follows one clock later.
                        if (asm_full) begin
                            mem_we   <= 1'b1;
                            mem_data <= asm_word;
                            rx_ready <= 1'b0;
                            state    <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    mem_addr  <= mem_addr + 1'b1;
                    remaining <= remaining - 9'd1;
                    if (remaining == 9'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state    <= ST_CHK;
                        rx_ready <= 1'b1;
`else
                        state     <= ST_FIN;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
`endif
                    end else begin
                        state    <= ST_DATA;
                        rx_ready <= 1'b1;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        if (rx_data == chk) begin
                            state     <= ST_FIN;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            // Program is invalid: keep the CPU held.
                            state    <= ST_ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    state    <= ST_IDLE;
                    rx_ready <= 1'b1;
                end
`endif
                ST_FIN: begin
                    state    <= ST_IDLE;
                    rx_ready <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    rx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int WW  = 24;
    localparam int AB  = 8;
    localparam int BPW = WW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          mem_we;
    logic [AB-1:0] mem_addr;
    logic [WW-1:0] mem_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;

    prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [31:0]   exp_q[$];    // {addr, word} in expected write order
    logic [WW-1:0] wq[$];       // preset words for directed frames
    logic [WW-1:0] last_word;
    logic          tb_last = 1'b0;  // current byte completes a word
    logic          we_due  = 1'b0;
    int            done_cnt = 0;
    int            exp_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Write strobe is due one clock after the last byte of a word is taken.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            we_due <= 1'b0;
        end else begin
            we_due <= rx_valid && rx_ready && tb_last;
            if (load_done) done_cnt <= done_cnt + 1;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && (mem_we || we_due)) begin
            check("we_latency", {31'd0, mem_we}, {31'd0, we_due});
            if (mem_we) begin
                check("ready_low_in_write", {31'd0, rx_ready}, 32'd0);
                check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", {24'd0, mem_addr}, {24'd0, e[31:24]});
                    check("wr_data", {8'd0, mem_data}, {8'd0, e[23:0]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        rx_valid = 1'b0;
        tb_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        tb_last  = last;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        tb_last = 1'b0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int len, input bit gaps, input bit bad_chk);
        int            nw;
        logic [7:0]    chk;
        logic [WW-1:0] w;
        logic [7:0]    b;
        nw = (len == 0) ? 256 : len;
        send_byte(8'hA5, 1'b0, gaps);
        send_byte(8'(len), 1'b0, gaps);
        check("hold_while_loading", {31'd0, cpu_hold}, 32'd1);
        chk = 8'(len);
        for (int i = 0; i < nw; i++) begin
            if (wq.size() != 0) w = wq.pop_front();
            else w = WW'($urandom);
            last_word = w;
            exp_q.push_back({8'(i % (1 << AB)), w});
            for (int k = BPW - 1; k >= 0; k--) begin
                b = w[k*8 +: 8];
                chk ^= b;
                send_byte(b, k == 0, gaps);
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (bad_chk) send_byte((chk == 8'h00) ? 8'hFF : 8'h00, 1'b0, gaps);
        else send_byte(chk, 1'b0, gaps);
        if (!bad_chk) exp_done++;
`else
        if (bad_chk) exp_done++;
        else exp_done++;
`endif
        idle(4);
        check("done_count", done_cnt, exp_done);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
        check({tag, "_mem_data"}, {8'd0, mem_data}, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        check({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Two-word frame with fixed content.
        wq = '{24'h010005, 24'h040001};
        send_frame(2, 1'b0, 1'b0);
        check("t1_hold_released", {31'd0, cpu_hold}, 32'd0);
        check("t1_addr_after", {24'd0, mem_addr}, 32'd2);

        // Noise before a frame is discarded.
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h7F, 1'b0, 1'b0);
        idle(2);
        check("t2_noise_no_hold", {31'd0, cpu_hold}, 32'd0);
        wq = '{24'h0A1234};
        send_frame(1, 1'b0, 1'b0);
        check("t2_no_err", {31'd0, load_err}, 32'd0);
        check("t2_mem_data_held", {8'd0, mem_data}, 32'h000A1234);

        // Random frames at full rate and with random gaps.
        for (int f = 0; f < 4; f++) send_frame($urandom_range(1, 6), 1'b0, 1'b0);
        for (int f = 0; f < 6; f++) send_frame($urandom_range(1, 8), 1'b1, 1'b0);
        check("rand_hold_released", {31'd0, cpu_hold}, 32'd0);

        // LEN=0: 256 words, address wraps back to 0 afterwards.
        send_frame(0, 1'b0, 1'b0);
        check("t3_addr_wrapped", {24'd0, mem_addr}, 32'd0);
        check("t3_data_held", {8'd0, mem_data}, {8'd0, last_word});
        check("t3_hold_released", {31'd0, cpu_hold}, 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        wq = '{24'h010005};
        send_frame(1, 1'b0, 1'b0);
        check("t5_good_no_err", {31'd0, load_err}, 32'd0);
        wq = '{24'h010005};
        send_frame(1, 1'b0, 1'b1);
        check("t5_bad_err", {31'd0, load_err}, 32'd1);
        check("t5_bad_hold", {31'd0, cpu_hold}, 32'd1);
        send_frame($urandom_range(1, 4), 1'b1, 1'b0);
        check("t5_err_cleared", {31'd0, load_err}, 32'd0);
        check("t5_hold_released", {31'd0, cpu_hold}, 32'd0);
`endif

        // Reset in the middle of the second word.
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        exp_q.push_back({8'd0, 24'hABCDEF});
        send_byte(8'hAB, 1'b0, 1'b0);
        send_byte(8'hCD, 1'b0, 1'b0);
        send_byte(8'hEF, 1'b1, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_values("t6_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(6);
        check("t6_no_done", done_cnt, exp_done);
        check("t6_hold_low", {31'd0, cpu_hold}, 32'd0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
